// File: rtl/id_decode_stage_if.sv
// Fetch->decode->execute handshake bundle for the RV32I decode stage.
// slave = the decode stage, master = the surrounding pipeline (fetch + execute).
interface id_decode_stage_if #(parameter int width = 32);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in_instr;
    logic [width-1:0] in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_aluOp;
    logic [3:0]       out_func;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [width-1:0] out_imm;
    logic             out_aluSrc;
    logic             out_regWrite;
    logic             out_memRead;
    logic             out_memWrite;
    logic [1:0]       out_branch;
    logic             out_illegal;
    logic [width-1:0] out_pc;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_aluOp, out_func, out_rs1, out_rs2, out_rd, out_imm,
               out_aluSrc, out_regWrite, out_memRead, out_memWrite, out_branch, out_illegal, out_pc
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_aluOp, out_func, out_rs1, out_rs2, out_rd, out_imm,
               out_aluSrc, out_regWrite, out_memRead, out_memWrite, out_branch, out_illegal, out_pc
    );
endinterface

// File: rtl/id_decode_stage.sv
// RV32I subset decode stage: one registered output slot (EMPTY/FULL), valid/ready
// on both sides, flush kills the held bundle and blocks acceptance for that cycle.
module id_decode_stage #(parameter int width = 32) (
    input  logic             clk,
    input  logic             reset,
    id_decode_stage_if.slave bus
);
    typedef struct packed {
        logic [2:0]       aluOp;
        logic [3:0]       func;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [width-1:0] imm;
        logic             aluSrc;
        logic             regWrite;
        logic             memRead;
        logic             memWrite;
        logic [1:0]       branch;
        logic             illegal;
        logic [width-1:0] pc;
    } bundle_t;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           r_state;
    bundle_t          r_bundle;
    bundle_t          w_dec;
    logic             w_accept;
    logic [2:0]       w_f3m;
    logic             w_f3ok;
    logic [6:0]       w_opcode;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic [width-1:0] w_instr;

    assign w_instr  = bus.in_instr;
    assign w_opcode = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];

    assign bus.in_ready = ((r_state == EMPTY) | bus.out_ready) & ~bus.flush;
    assign w_accept     = bus.in_valid & bus.in_ready;

    // ALU func encodes or/xor swapped relative to RISC-V funct3
    always_comb begin
        w_f3m  = w_f3;
        w_f3ok = 1'b0;
        case (w_f3)
            3'b000: begin w_f3m = 3'b000; w_f3ok = 1'b1; end
            3'b100: begin w_f3m = 3'b110; w_f3ok = 1'b1; end
            3'b110: begin w_f3m = 3'b100; w_f3ok = 1'b1; end
            3'b111: begin w_f3m = 3'b111; w_f3ok = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        w_dec     = '0;
        w_dec.rs1 = w_instr[19:15];
        w_dec.rs2 = w_instr[24:20];
        w_dec.rd  = w_instr[11:7];
        w_dec.pc  = bus.in_pc;
        case (w_opcode)
            7'b0110011: begin
                if ((w_f7 == 7'b0000000 && w_f3ok) || (w_f7 == 7'b0100000 && w_f3 == 3'b000)) begin
                    w_dec.aluOp    = 3'b010;
                    w_dec.func     = {w_instr[30], w_f3m};
                    w_dec.regWrite = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            7'b0010011: begin
                if (w_f3ok) begin
                    w_dec.aluOp    = 3'b010;
                    w_dec.func     = {1'b0, w_f3m};
                    w_dec.aluSrc   = 1'b1;
                    w_dec.regWrite = 1'b1;
                    w_dec.imm      = {{(width-12){w_instr[31]}}, w_instr[31:20]};
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            7'b0000011: begin
                if (w_f3 == 3'b010) begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.memRead  = 1'b1;
                    w_dec.regWrite = 1'b1;
                    w_dec.imm      = {{(width-12){w_instr[31]}}, w_instr[31:20]};
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            7'b0100011: begin
                if (w_f3 == 3'b010) begin
                    w_dec.aluSrc   = 1'b1;
                    w_dec.memWrite = 1'b1;
                    w_dec.imm      = {{(width-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            7'b1100011: begin
                if (w_f3 == 3'b000 || w_f3 == 3'b001) begin
                    w_dec.aluOp  = 3'b001;
                    w_dec.branch = (w_f3 == 3'b000) ? 2'b01 : 2'b10;
                    w_dec.imm    = {{(width-13){w_instr[31]}}, w_instr[31], w_instr[7],
                                    w_instr[30:25], w_instr[11:8], 1'b0};
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: w_dec.illegal = 1'b1;
        endcase
        if (w_dec.rd == 5'd0) w_dec.regWrite = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= EMPTY;
            r_bundle <= '0;
        end else if (bus.flush) begin
            r_state <= EMPTY;
        end else if (w_accept) begin
            r_state  <= FULL;
            r_bundle <= w_dec;
        end else if (bus.out_ready) begin
            r_state <= EMPTY;
        end
    end

    assign bus.out_valid    = (r_state == FULL);
    assign bus.out_aluOp    = r_bundle.aluOp;
    assign bus.out_func     = r_bundle.func;
    assign bus.out_rs1      = r_bundle.rs1;
    assign bus.out_rs2      = r_bundle.rs2;
    assign bus.out_rd       = r_bundle.rd;
    assign bus.out_imm      = r_bundle.imm;
    assign bus.out_aluSrc   = r_bundle.aluSrc;
    assign bus.out_regWrite = r_bundle.regWrite;
    assign bus.out_memRead  = r_bundle.memRead;
    assign bus.out_memWrite = r_bundle.memWrite;
    assign bus.out_branch   = r_bundle.branch;
    assign bus.out_illegal  = r_bundle.illegal;
    assign bus.out_pc       = r_bundle.pc;
endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vectors, stall, flush and streaming.
module tb_id_decode_stage;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    id_decode_stage_if #(.width(32)) bus();
    id_decode_stage #(.width(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        step();
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_aluOp", bus.out_aluOp, 0);
        chk("rst_imm", bus.out_imm, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_rd", bus.out_rd, 0);
        chk("rst_illegal", bus.out_illegal, 0);
        chk("rst_regWrite", bus.out_regWrite, 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // add x3,x1,x2
        send(32'h002081B3, 32'h100);
        chk("add_valid", bus.out_valid, 1);
        chk("add_aluOp", bus.out_aluOp, 3'b010);
        chk("add_func", bus.out_func, 4'b0000);
        chk("add_rd", bus.out_rd, 3);
        chk("add_rs1", bus.out_rs1, 1);
        chk("add_rs2", bus.out_rs2, 2);
        chk("add_regWrite", bus.out_regWrite, 1);
        chk("add_aluSrc", bus.out_aluSrc, 0);
        chk("add_pc", bus.out_pc, 32'h100);

        send(32'h402081B3, 32'h104);
        chk("sub_valid", bus.out_valid, 1);
        chk("sub_func", bus.out_func, 4'b1000);
        chk("sub_pc", bus.out_pc, 32'h104);

        // xori x5,x1,-1
        send(32'hFFF0C293, 32'h108);
        chk("xori_aluOp", bus.out_aluOp, 3'b010);
        chk("xori_func", bus.out_func, 4'b0110);
        chk("xori_imm", bus.out_imm, 32'hFFFFFFFF);
        chk("xori_aluSrc", bus.out_aluSrc, 1);
        chk("xori_rd", bus.out_rd, 5);
        chk("xori_regWrite", bus.out_regWrite, 1);

        // beq x1,x2,-4
        send(32'hFE208EE3, 32'h10C);
        chk("beq_aluOp", bus.out_aluOp, 3'b001);
        chk("beq_branch", bus.out_branch, 2'b01);
        chk("beq_imm", bus.out_imm, 32'hFFFFFFFC);
        chk("beq_regWrite", bus.out_regWrite, 0);
        chk("beq_rd_raw", bus.out_rd, 29);

        // sll is not supported
        send(32'h002091B3, 32'h110);
        chk("sll_valid", bus.out_valid, 1);
        chk("sll_illegal", bus.out_illegal, 1);
        chk("sll_regWrite", bus.out_regWrite, 0);
        chk("sll_aluOp", bus.out_aluOp, 0);
        chk("sll_func", bus.out_func, 0);
        chk("sll_imm", bus.out_imm, 0);

        // funct7=0100000 only legal with funct3=000
        send(32'h4020C1B3, 32'h114);
        chk("subxor_illegal", bus.out_illegal, 1);

        // lw x7,8(x2)
        send(32'h00812383, 32'h118);
        chk("lw_illegal", bus.out_illegal, 0);
        chk("lw_memRead", bus.out_memRead, 1);
        chk("lw_imm", bus.out_imm, 8);
        chk("lw_aluOp", bus.out_aluOp, 0);
        chk("lw_regWrite", bus.out_regWrite, 1);

        // sw x5,-8(x2)
        send(32'hFE512C23, 32'h11C);
        chk("sw_memWrite", bus.out_memWrite, 1);
        chk("sw_memRead", bus.out_memRead, 0);
        chk("sw_imm", bus.out_imm, 32'hFFFFFFF8);
        chk("sw_regWrite", bus.out_regWrite, 0);
        chk("sw_rs2", bus.out_rs2, 5);

        // add x0,x1,x2: write to x0 suppressed
        send(32'h00208033, 32'h120);
        chk("rd0_regWrite", bus.out_regWrite, 0);
        chk("rd0_func", bus.out_func, 0);

        // stall with a pending or x4,x1,x2
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0020E233;
        bus.in_pc     = 32'h124;
        #1;
        chk("stall_in_ready0", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_pc", bus.out_pc, 32'h120);
            chk("stall_rd", bus.out_rd, 0);
            chk("stall_in_ready", bus.in_ready, 0);
        end

        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", bus.out_valid, 0);
        step();
        chk("flush_no_pending", bus.out_valid, 0);

        // back-to-back stream
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(32'h0020E233, 32'h200 + 4 * i);
            chk("stream_valid", bus.out_valid, 1);
            chk("stream_pc", bus.out_pc, 32'h200 + 4 * i);
            chk("stream_func", bus.out_func, 4'b0100);
        end
        bus.in_valid = 1'b0;
        step();
        chk("drain_valid", bus.out_valid, 0);

        // flush while in_valid with empty slot: nothing accepted
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        step();
        chk("flush_empty_valid", bus.out_valid, 0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
